// File: rtl/rr_bank_arbiter.sv
// Round-robin arbiter of NCONSUMERS requesters onto NBANKS x NPORTS PLM ports with read-data return.
// Optional per-kernel saturating grant counters are added when RR_PERF_CNT_EN is defined.
module rr_bank_arbiter #(
   parameter int ADDR_WIDTH  = 4,
   parameter int VALUE_WIDTH = 8,
   parameter int NCONSUMERS  = 4,
   parameter int NBANKS      = 2,
   parameter int NPORTS      = 2,
   parameter int PLM_LATENCY = 1,
   localparam int NUM_BANK_BITS = $clog2(NBANKS),
   localparam int REQ_W = ADDR_WIDTH + VALUE_WIDTH + 2,
   localparam int PLM_W = ADDR_WIDTH - NUM_BANK_BITS + VALUE_WIDTH + 1,
   localparam int NK    = NBANKS * NPORTS
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [REQ_W-1:0]       requests [NCONSUMERS],
   output logic [NCONSUMERS-1:0]  grants,
   output logic [PLM_W-1:0]       plm_inputs [NK],
   output logic [NK-1:0]          plm_en,
   input  logic [VALUE_WIDTH-1:0] plm_outputs [NK],
`ifdef RR_PERF_CNT_EN
   output logic [31:0]            grant_cnt [NK],
`endif
   output logic [VALUE_WIDTH-1:0] resp_data [NCONSUMERS],
   output logic [NCONSUMERS-1:0]  resp_valid
);

   localparam int NLOCAL = NCONSUMERS / NPORTS;
   localparam int LA_W   = ADDR_WIDTH - NUM_BANK_BITS;
   localparam int PW     = (NLOCAL > 1) ? $clog2(NLOCAL) : 1;
   localparam int CW     = (NCONSUMERS > 1) ? $clog2(NCONSUMERS) : 1;

   if (!(NPORTS == 1 || NPORTS == 2)) begin : g_bad_nports
      $error("rr_bank_arbiter: NPORTS must be 1 or 2");
   end
   if (NCONSUMERS % NPORTS != 0) begin : g_bad_ncons
      $error("rr_bank_arbiter: NCONSUMERS must be a multiple of NPORTS");
   end

   logic [PW-1:0]          pivot_q [NK];
   logic [PW-1:0]          pivot_d [NK];
   logic [NK-1:0]          win_rd;
   logic [CW-1:0]          win_id [NK];
   logic [PLM_LATENCY-1:0] pipe_vld_q [NK];
   logic [CW-1:0]          pipe_id_q [NK][PLM_LATENCY];
   int                     scan_idx;
   int                     scan_c;
   logic [CW-1:0]          scan_id;

   // Bank bits are the address bits above the local field; with one bank the shift yields 0.
   function automatic logic eligible(input logic [REQ_W-1:0] r, input int bank);
      logic [ADDR_WIDTH-1:0] a;
      a = r[REQ_W-1 -: ADDR_WIDTH];
      return r[0] && (int'(a >> LA_W) == bank);
   endfunction

   always_comb begin
      grants   = '0;
      plm_en   = '0;
      win_rd   = '0;
      scan_idx = 0;
      scan_c   = 0;
      scan_id  = '0;
      for (int k = 0; k < NK; k++) begin
         plm_inputs[k] = '0;
         pivot_d[k]    = pivot_q[k];
         win_id[k]     = '0;
         for (int j = 0; j < NLOCAL; j++) begin
            scan_idx = int'(pivot_q[k]) + j;
            if (scan_idx >= NLOCAL) scan_idx = scan_idx - NLOCAL;
            scan_c  = scan_idx * NPORTS + (k % NPORTS);
            scan_id = CW'(scan_c);
            if (!plm_en[k] && eligible(requests[scan_id], k / NPORTS)) begin
               plm_en[k]       = 1'b1;
               grants[scan_id] = 1'b1;
               // {local addr, value, wr} is contiguous once the bank bits are dropped
               plm_inputs[k]   = requests[scan_id][LA_W+VALUE_WIDTH+1:1];
               win_rd[k]       = ~requests[scan_id][1];
               win_id[k]       = scan_id;
               pivot_d[k]      = (scan_idx == NLOCAL - 1) ? '0 : PW'(scan_idx + 1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < NK; k++) begin
         if (reset) begin
            pivot_q[k]    <= PW'((k / NPORTS) % NLOCAL);
            pipe_vld_q[k] <= '0;
         end else begin
            pivot_q[k]       <= pivot_d[k];
            pipe_vld_q[k][0] <= win_rd[k];
            for (int s = 1; s < PLM_LATENCY; s++) pipe_vld_q[k][s] <= pipe_vld_q[k][s-1];
         end
         pipe_id_q[k][0] <= win_id[k];
         for (int s = 1; s < PLM_LATENCY; s++) pipe_id_q[k][s] <= pipe_id_q[k][s-1];
      end
   end

   // Every kernel has the same latency and a consumer wins at most once per cycle, so retirements never collide.
   always_ff @(posedge clk) begin
      if (reset) begin
         resp_valid <= '0;
         for (int c = 0; c < NCONSUMERS; c++) resp_data[c] <= '0;
      end else begin
         resp_valid <= '0;
         for (int k = 0; k < NK; k++) begin
            if (pipe_vld_q[k][PLM_LATENCY-1]) begin
               resp_valid[pipe_id_q[k][PLM_LATENCY-1]] <= 1'b1;
               resp_data[pipe_id_q[k][PLM_LATENCY-1]]  <= plm_outputs[k];
            end
         end
      end
   end

`ifdef RR_PERF_CNT_EN
   always_ff @(posedge clk) begin
      for (int k = 0; k < NK; k++) begin
         if (reset) grant_cnt[k] <= '0;
         else if (plm_en[k] && (grant_cnt[k] != 32'hFFFF_FFFF)) grant_cnt[k] <= grant_cnt[k] + 32'd1;
      end
   end
`endif

endmodule
